// File: rtl/joy_dir_filter.sv
// Multi-player joystick direction conditioner: per-bit debounce followed by a
// shared run-time restriction mode (pass, 4-way, 2-way horizontal, 2-way vertical).
module joy_dir_filter #(
  parameter int PLAYERS    = 2,
  parameter int DEB_CYCLES = 0
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [1:0]             mode,
  input  logic [4*PLAYERS-1:0]   joy_in,
  output logic [4*PLAYERS-1:0]   joy_out,
  output logic [PLAYERS-1:0]     changed
);

  localparam int D  = (DEB_CYCLES > 1) ? DEB_CYCLES : 1;
  localparam int CW = (D > 1) ? $clog2(D) : 1;
  localparam int NB = 4 * PLAYERS;
  localparam logic [CW-1:0] CNT_MAX = CW'(D - 1);

  typedef enum logic [1:0] {
    MODE_PASS  = 2'd0,
    MODE_WAY4  = 2'd1,
    MODE_WAY2H = 2'd2,
    MODE_WAY2V = 2'd3
  } mode_e;

  logic [NB-1:0]      deb_q, deb_d;
  logic [NB-1:0]      prev_q, prev_d;
  logic [NB-1:0]      msk_q, msk_d;
  logic [NB-1:0]      out_q, out_d;
  logic [PLAYERS-1:0] changed_q, changed_d;
  logic [1:0]         mode_q, mode_d;
  logic [CW-1:0]      cnt_q [NB];
  logic [CW-1:0]      cnt_d [NB];

  // One-hot of the highest set bit; up (bit 3) has top priority.
  function automatic logic [3:0] prio(input logic [3:0] x);
    logic [3:0] r;
    r = 4'b0000;
    if (x[3])      r = 4'b1000;
    else if (x[2]) r = 4'b0100;
    else if (x[1]) r = 4'b0010;
    else if (x[0]) r = 4'b0001;
    return r;
  endfunction

  always_comb begin
    deb_d = deb_q;
    for (int i = 0; i < NB; i++) begin
      cnt_d[i] = '0;
      if (joy_in[i] == deb_q[i]) begin
        cnt_d[i] = '0;
      end else if (cnt_q[i] == CNT_MAX) begin
        deb_d[i] = joy_in[i];
        cnt_d[i] = '0;
      end else begin
        cnt_d[i] = cnt_q[i] + CW'(1);
      end
    end
  end

  logic [3:0] mode_mask;
  logic [3:0] md, nw, nmsk, nout;

  always_comb begin
    mode_mask = 4'b1111;
    case (mode_e'(mode))
      MODE_WAY2H: mode_mask = 4'b0011;
      MODE_WAY2V: mode_mask = 4'b1100;
      default:    mode_mask = 4'b1111;
    endcase

    prev_d    = deb_q;
    mode_d    = mode;
    msk_d     = msk_q;
    out_d     = out_q;
    changed_d = '0;
    md        = 4'b0000;
    nw        = 4'b0000;
    nmsk      = 4'b1111;
    nout      = 4'b0000;

    for (int p = 0; p < PLAYERS; p++) begin
      md = deb_q[4*p +: 4] & mode_mask;
      nw = deb_q[4*p +: 4] & ~prev_q[4*p +: 4] & mode_mask;
      // A mode switch wipes the lock so no stale one-hot from the old mode survives.
      if (mode != mode_q)                      nmsk = 4'b1111;
      else if (nw != 4'b0000)                  nmsk = prio(nw);
      else if ((md & msk_q[4*p +: 4]) == 4'b0) nmsk = 4'b1111;
      else                                     nmsk = msk_q[4*p +: 4];

      if (mode_e'(mode) == MODE_PASS) nout = deb_q[4*p +: 4];
      else                            nout = prio(md & nmsk);

      msk_d[4*p +: 4] = nmsk;
      out_d[4*p +: 4] = nout;
      changed_d[p]    = (nout != out_q[4*p +: 4]);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      deb_q     <= '0;
      prev_q    <= '0;
      msk_q     <= '1;
      out_q     <= '0;
      changed_q <= '0;
      mode_q    <= 2'd0;
      for (int i = 0; i < NB; i++) cnt_q[i] <= '0;
    end else begin
      deb_q     <= deb_d;
      prev_q    <= prev_d;
      msk_q     <= msk_d;
      out_q     <= out_d;
      changed_q <= changed_d;
      mode_q    <= mode_d;
      cnt_q     <= cnt_d;
    end
  end

  assign joy_out = out_q;
  assign changed = changed_q;

endmodule
